// File: rtl/fft_pkg.sv
// Shared FFT constants and sample type used by the reorder buffer and its neighbours.
package fft_pkg;

  localparam int FFT_LOG2N  = 6;
  localparam int FFT_N      = 1 << FFT_LOG2N;
  localparam int FFT_DATA_W = 32;

  // Packed complex sample: real part in the upper half, imaginary in the lower half.
  typedef struct packed {
    logic signed [FFT_DATA_W/2-1:0] re;
    logic signed [FFT_DATA_W/2-1:0] im;
  } cplx_t;

endpackage

// File: rtl/bit_reverse.sv
// Combinational index reversal: bit k of the input lands on bit W-1-k of the output.
module bit_reverse #(
  parameter int W = 6
) (
  input  logic [W-1:0] idx_in,
  output logic [W-1:0] idx_out
);

  for (genvar gi = 0; gi < W; gi++) begin : g_rev
    assign idx_out[gi] = idx_in[W-1-gi];
  end

endmodule

// File: rtl/bitrev_reorder_buffer.sv
// Ping-pong reorder buffer: fills one bank in natural order while the other drains
// either bit-reversed or in natural order, one sample per cycle on each side.
module bitrev_reorder_buffer
  import fft_pkg::*;
#(
  parameter int LOG2N  = FFT_LOG2N,
  parameter int DATA_W = FFT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reverse_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_last
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  logic [DATA_W-1:0] bank_mem [2][N];

  logic             w_sel_q, w_sel_d;
  logic             r_sel_q, r_sel_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]       full_q, full_d;
  logic [1:0]       mode_q, mode_d;
  logic [LOG2N-1:0] rd_cnt_rev;
  logic [LOG2N-1:0] rd_addr;
  logic             in_fire;
  logic             out_fire;

  // Handshake flags come straight from state so neither side sees the other's strobes.
  assign in_ready  = ~full_q[w_sel_q];
  assign out_valid = full_q[r_sel_q];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  bit_reverse #(.W(LOG2N)) u_bit_reverse (
    .idx_in  (rd_cnt_q),
    .idx_out (rd_cnt_rev)
  );

  assign rd_addr   = mode_q[r_sel_q] ? rd_cnt_rev : rd_cnt_q;
  assign out_data  = bank_mem[r_sel_q][rd_addr];
  assign out_index = rd_addr;
  assign out_last  = out_valid & (rd_cnt_q == CNT_LAST);

  always_comb begin
    w_sel_d  = w_sel_q;
    r_sel_d  = r_sel_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    full_d   = full_q;
    mode_d   = mode_q;

    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == '0) begin
        mode_d[w_sel_q] = reverse_en;
      end
      if (wr_cnt_q == CNT_LAST) begin
        full_d[w_sel_q] = 1'b1;
        w_sel_d         = ~w_sel_q;
      end
    end

    // The reader only ever clears the bank it owns, which the writer cannot be filling.
    if (out_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == CNT_LAST) begin
        full_d[r_sel_q] = 1'b0;
        r_sel_d         = ~r_sel_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_sel_q  <= 1'b0;
      r_sel_q  <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      full_q   <= 2'b00;
      mode_q   <= 2'b00;
    end else begin
      w_sel_q  <= w_sel_d;
      r_sel_q  <= r_sel_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      full_q   <= full_d;
      mode_q   <= mode_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      bank_mem[w_sel_q][wr_cnt_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_bitrev_reorder_buffer.sv
// Scoreboard bench for the reorder buffer: an 8-point instance for directed
// scenarios and a default 64-point instance for randomly throttled traffic.
module tb_bitrev_reorder_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        rev3, iv3, ir3, ov3, or3, ol3;
  logic [31:0] id3, od3;
  logic [2:0]  oi3;

  logic        rev6, iv6, ir6, ov6, or6, ol6;
  logic [31:0] id6, od6;
  logic [5:0]  oi6;

  bitrev_reorder_buffer #(.LOG2N(3), .DATA_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .reverse_en(rev3),
    .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .out_index(oi3), .out_last(ol3)
  );

  bitrev_reorder_buffer u_dut6 (
    .clk(clk), .rst(rst), .reverse_en(rev6),
    .in_valid(iv6), .in_ready(ir6), .in_data(id6),
    .out_valid(ov6), .out_ready(or6), .out_data(od6),
    .out_index(oi6), .out_last(ol6)
  );

  typedef struct {
    logic [31:0] data;
    int          idx;
    logic        last;
  } exp_t;

  exp_t q3[$];
  exp_t q6[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  int          wc3 = 0;
  logic        fm3 = 1'b0;
  logic [31:0] fb3 [8];
  int          wc6 = 0;
  logic        fm6 = 1'b0;
  logic [31:0] fb6 [64];

  function automatic int bitrev(input int v, input int n);
    int r = 0;
    for (int k = 0; k < n; k++) begin
      if (v[k]) r = r | (1 << (n - 1 - k));
    end
    return r;
  endfunction

  // One cycle on the 8-point instance: drive, sample at the falling edge, and push the
  // expected reordered frame once its last sample is accepted.
  task automatic cyc3(input logic v, input logic [31:0] d, input logic rdy, input logic rev,
                      output logic acc, output logic xfer, output logic [31:0] od,
                      output logic [2:0] oi, output logic ol);
    exp_t e;
    iv3 = v; id3 = d; or3 = rdy; rev3 = rev;
    #1;
    acc = iv3 & ir3; xfer = ov3 & or3; od = od3; oi = oi3; ol = ol3;
    if (acc) begin
      if (wc3 == 0) fm3 = rev;
      fb3[wc3] = d;
      wc3++;
      if (wc3 == 8) begin
        for (int k = 0; k < 8; k++) begin
          e.idx  = fm3 ? bitrev(k, 3) : k;
          e.data = fb3[e.idx];
          e.last = (k == 7);
          q3.push_back(e);
        end
        wc3 = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc6(input logic v, input logic [31:0] d, input logic rdy, input logic rev,
                      output logic acc, output logic xfer, output logic [31:0] od,
                      output logic [5:0] oi, output logic ol);
    exp_t e;
    iv6 = v; id6 = d; or6 = rdy; rev6 = rev;
    #1;
    acc = iv6 & ir6; xfer = ov6 & or6; od = od6; oi = oi6; ol = ol6;
    if (acc) begin
      if (wc6 == 0) fm6 = rev;
      fb6[wc6] = d;
      wc6++;
      if (wc6 == 64) begin
        for (int k = 0; k < 64; k++) begin
          e.idx  = fm6 ? bitrev(k, 6) : k;
          e.data = fb6[e.idx];
          e.last = (k == 63);
          q6.push_back(e);
        end
        wc6 = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv3 = 1'b0; or3 = 1'b0; rev3 = 1'b0; id3 = '0;
    iv6 = 1'b0; or6 = 1'b0; rev6 = 1'b0; id6 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (ir3 !== 1'b1) $display("FAIL reset_in_ready3: got %b want 1", ir3); else pass_cnt++;
    total_cnt++; if (ov3 !== 1'b0) $display("FAIL reset_out_valid3: got %b want 0", ov3); else pass_cnt++;
    total_cnt++; if (ol3 !== 1'b0) $display("FAIL reset_out_last3: got %b want 0", ol3); else pass_cnt++;
    total_cnt++; if (oi3 !== 3'd0) $display("FAIL reset_out_index3: got %0d want 0", oi3); else pass_cnt++;
    total_cnt++; if (ir6 !== 1'b1) $display("FAIL reset_in_ready6: got %b want 1", ir6); else pass_cnt++;
    total_cnt++; if (ov6 !== 1'b0) $display("FAIL reset_out_valid6: got %b want 0", ov6); else pass_cnt++;
    $display("test_reset done");
    @(negedge clk);
  endtask

  task automatic test_basic_reverse();
    int tbl[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int sent = 0, n_out = 0, acc_cyc = -100, first_cyc = -1;
    logic acc, xfer, ol;
    logic [31:0] od;
    logic [2:0] oi;
    exp_t e;
    for (int c = 0; c < 60 && (sent < 8 || q3.size() > 0); c++) begin
      cyc3(sent < 8, 32'(sent), 1'b1, 1'b1, acc, xfer, od, oi, ol);
      if (acc) begin
        sent++;
        if (sent == 8) acc_cyc = c;
      end
      if (xfer) begin
        if (first_cyc < 0) first_cyc = c;
        if (q3.size() > 0) e = q3.pop_front();
        total_cnt++;
        if (n_out > 7 || od !== 32'(tbl[n_out]) || int'(oi) != tbl[n_out] || ol !== (n_out == 7))
          $display("FAIL basic_order: out#%0d data=%0d index=%0d last=%b required data=index=%0d last=%b",
                   n_out, od, oi, ol, (n_out > 7) ? -1 : tbl[n_out], n_out == 7);
        else pass_cnt++;
        $display("basic out#%0d data=%0d index=%0d last=%b", n_out, od, oi, ol);
        n_out++;
      end
    end
    total_cnt++; if (first_cyc - acc_cyc != 1) $display("FAIL basic_latency: got %0d cycles required 1", first_cyc - acc_cyc); else pass_cnt++;
    total_cnt++; if (n_out != 8) $display("FAIL basic_count: got %0d outputs required 8", n_out); else pass_cnt++;
  endtask

  task automatic test_passthrough();
    int sent = 0, n_out = 0;
    logic acc, xfer, ol;
    logic [31:0] od;
    logic [2:0] oi;
    for (int c = 0; c < 60 && (sent < 8 || q3.size() > 0 || n_out == 0); c++) begin
      cyc3(sent < 8, 32'(10 + sent), 1'b1, 1'b0, acc, xfer, od, oi, ol);
      if (acc) sent++;
      if (xfer) begin
        if (q3.size() > 0) void'(q3.pop_front());
        total_cnt++;
        if (od !== 32'(10 + n_out) || int'(oi) != n_out || ol !== (n_out == 7))
          $display("FAIL pass_order: out#%0d data=%0d index=%0d last=%b required %0d/%0d/%b",
                   n_out, od, oi, ol, 10 + n_out, n_out, n_out == 7);
        else pass_cnt++;
        $display("pass out#%0d data=%0d index=%0d", n_out, od, oi);
        n_out++;
      end
    end
    total_cnt++; if (n_out != 8) $display("FAIL pass_count: got %0d outputs required 8", n_out); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int sent = 0, n_out = 0;
    logic acc, xfer, ol, rev;
    logic [31:0] od;
    logic [2:0] oi;
    exp_t e;
    for (int c = 0; c < 120 && (sent < 24 || q3.size() > 0); c++) begin
      rev = (sent < 4) || (sent >= 12);
      if (sent < 24) begin
        #1;
        total_cnt++; if (ir3 !== 1'b1) $display("FAIL b2b_in_ready: sample %0d got %b required 1", sent, ir3); else pass_cnt++;
      end
      cyc3(sent < 24, 32'(200 + sent), 1'b1, rev, acc, xfer, od, oi, ol);
      if (acc) sent++;
      if (xfer) begin
        total_cnt++;
        if (q3.size() == 0) $display("FAIL b2b_order: unexpected data=%0d required none", od);
        else begin
          e = q3.pop_front();
          if (od !== e.data || int'(oi) != e.idx || ol !== e.last)
            $display("FAIL b2b_order: out#%0d data=%0d index=%0d last=%b required %0d/%0d/%b",
                     n_out, od, oi, ol, e.data, e.idx, e.last);
          else pass_cnt++;
        end
        if (n_out == 1 || n_out == 9 || n_out == 17) begin
          total_cnt++;
          if (od !== ((n_out == 1) ? 32'd204 : (n_out == 9) ? 32'd209 : 32'd220))
            $display("FAIL b2b_mode: out#%0d data=%0d required %0d", n_out, od,
                     (n_out == 1) ? 204 : (n_out == 9) ? 209 : 220);
          else pass_cnt++;
        end
        $display("b2b out#%0d data=%0d index=%0d last=%b", n_out, od, oi, ol);
        n_out++;
      end
    end
    total_cnt++; if (n_out != 24) $display("FAIL b2b_count: got %0d outputs required 24", n_out); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int sent = 0, n_out = 0;
    logic acc, xfer, ol;
    logic [31:0] od;
    logic [2:0] oi;
    exp_t e;
    for (int c = 0; c < 20; c++) begin
      cyc3(1'b1, 32'(sent), 1'b0, 1'b1, acc, xfer, od, oi, ol);
      if (acc) sent++;
    end
    #1;
    total_cnt++; if (sent != 16) $display("FAIL bp_accepts: got %0d required 16", sent); else pass_cnt++;
    total_cnt++; if (ir3 !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", ir3); else pass_cnt++;
    total_cnt++; if (ov3 !== 1'b1) $display("FAIL bp_out_valid: got %b required 1", ov3); else pass_cnt++;
    total_cnt++; if (od3 !== 32'd0 || oi3 !== 3'd0 || ol3 !== 1'b0)
      $display("FAIL bp_hold: data=%0d index=%0d last=%b required 0/0/0", od3, oi3, ol3);
    else pass_cnt++;
    for (int c = 0; c < 80 && q3.size() > 0; c++) begin
      cyc3(1'b0, 32'd0, 1'b1, 1'b1, acc, xfer, od, oi, ol);
      if (xfer) begin
        e = q3.pop_front();
        total_cnt++;
        if (od !== e.data || int'(oi) != e.idx || ol !== e.last)
          $display("FAIL bp_drain: out#%0d data=%0d index=%0d last=%b required %0d/%0d/%b",
                   n_out, od, oi, ol, e.data, e.idx, e.last);
        else pass_cnt++;
        $display("bp out#%0d data=%0d index=%0d", n_out, od, oi);
        n_out++;
      end
    end
    total_cnt++; if (n_out != 16 || ov3 !== 1'b0) $display("FAIL bp_count: got %0d outputs valid=%b required 16 valid=0", n_out, ov3); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int sent = 0, n_out = 0;
    logic acc, xfer, ol;
    logic [31:0] od;
    logic [2:0] oi;
    exp_t e;
    for (int c = 0; c < 20 && sent < 13; c++) begin
      cyc3(1'b1, 32'(100 + sent), 1'b0, 1'b1, acc, xfer, od, oi, ol);
      if (acc) sent++;
    end
    iv3 = 1'b0; or3 = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if (ov3 !== 1'b0) $display("FAIL rstmid_out_valid: got %b required 0", ov3); else pass_cnt++;
    total_cnt++; if (ir3 !== 1'b1) $display("FAIL rstmid_in_ready: got %b required 1", ir3); else pass_cnt++;
    q3.delete();
    wc3 = 0;
    @(negedge clk);
    sent = 0;
    for (int c = 0; c < 60 && (sent < 8 || q3.size() > 0); c++) begin
      cyc3(sent < 8, 32'(sent), 1'b1, 1'b1, acc, xfer, od, oi, ol);
      if (acc) sent++;
      if (xfer) begin
        total_cnt++;
        if (q3.size() == 0) $display("FAIL rstmid_order: unexpected data=%0d required none", od);
        else begin
          e = q3.pop_front();
          if (od !== e.data || int'(oi) != e.idx || ol !== e.last)
            $display("FAIL rstmid_order: out#%0d data=%0d index=%0d required %0d/%0d", n_out, od, oi, e.data, e.idx);
          else pass_cnt++;
        end
        $display("rstmid out#%0d data=%0d index=%0d", n_out, od, oi);
        n_out++;
      end
    end
    for (int c = 0; c < 5; c++) begin
      cyc3(1'b0, 32'd0, 1'b1, 1'b1, acc, xfer, od, oi, ol);
      if (xfer) n_out++;
    end
    total_cnt++; if (n_out != 8) $display("FAIL rstmid_count: got %0d outputs required 8", n_out); else pass_cnt++;
  endtask

  task automatic test_random_64();
    int sent = 0, n_out = 0, n_last = 0;
    logic acc, xfer, ol, v, rdy;
    logic [31:0] od;
    logic [5:0] oi;
    exp_t e;
    for (int c = 0; c < 20000 && (sent < 1280 || q6.size() > 0); c++) begin
      v   = (sent < 1280) && ($urandom_range(0, 9) < 7);
      rdy = $urandom_range(0, 9) < 7;
      cyc6(v, $urandom, rdy, 1'b1, acc, xfer, od, oi, ol);
      if (acc) sent++;
      if (xfer) begin
        total_cnt++;
        if (q6.size() == 0) $display("FAIL rand_order: unexpected data=%0h required none", od);
        else begin
          e = q6.pop_front();
          if (od !== e.data || int'(oi) != e.idx || ol !== e.last)
            $display("FAIL rand_order: out#%0d data=%0h index=%0d last=%b required %0h/%0d/%b",
                     n_out, od, oi, ol, e.data, e.idx, e.last);
          else pass_cnt++;
        end
        if (ol) n_last++;
        n_out++;
      end
    end
    $display("random: %0d inputs, %0d outputs, %0d frames", sent, n_out, n_last);
    total_cnt++; if (n_out != 1280 || n_last != 20)
      $display("FAIL rand_count: got %0d outputs %0d lasts required 1280 and 20", n_out, n_last);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_reverse();
    test_passthrough();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_random_64();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
